// File: rtl/digit_entry_scan_if.sv
// digit_entry_scan_if: pushbutton inputs and display/status outputs of the
// digit entry block. master = board/driver side, slave = digit_entry_scan.
interface digit_entry_scan_if;
    logic        btn_inc;
    logic        btn_next;
    logic        btn_clr;
    logic        btn_eq;
    logic [4:0]  digit_val;
    logic [3:0]  digit_en;
    logic [15:0] value;
    logic [1:0]  cursor;
    logic        eq_flag;

    modport master (
        output btn_inc, btn_next, btn_clr, btn_eq,
        input  digit_val, digit_en, value, cursor, eq_flag
    );

    modport slave (
        input  btn_inc, btn_next, btn_clr, btn_eq,
        output digit_val, digit_en, value, cursor, eq_flag
    );
endinterface

// File: rtl/digit_entry_scan.sv
// digit_entry_scan: four-button hex word entry with a multiplexed 4-digit scan.
// Ports: clk, rst (sync, active-high); bus.slave carries btn_inc/next/clr/eq
// (raw, async) in and digit_val, digit_en (active-low), value, cursor,
// eq_flag out. Optional macro CURSOR_BLINK_EN blanks the edited digit.
module digit_entry_scan #(
    parameter int DEB_N  = 20,
    parameter int SCAN_N = 18
) (
    input  logic         clk,
    input  logic         rst,
    digit_entry_scan_if.slave bus
);
    // Button order in all vectors: {eq, clr, next, inc}
    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       level;
    logic [3:0]       pulse;
    logic [DEB_N-1:0] deb_cnt [4];

    logic [15:0]       val_q;
    logic [1:0]        cur_q;
    logic              eq_q;
    logic [SCAN_N-1:0] scan_cnt;
    logic [1:0]        sel;
    logic [3:0]        en_q;
    logic [4:0]        dval_q;
    logic              blank;

    assign raw = {bus.btn_eq, bus.btn_clr, bus.btn_next, bus.btn_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A pulse is emitted only when the level is accepted as 1, so each
    // debounced rising edge yields exactly one pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            pulse <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pulse[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (&deb_cnt[i]) begin
                    deb_cnt[i] <= '0;
                    level[i]   <= sync2[i];
                    pulse[i]   <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_N'(1);
                end
            end
        end
    end

    // Increment uses the old cursor; the cursor advance lands alongside it.
    always_ff @(posedge clk) begin
        if (rst || pulse[2]) begin
            val_q <= '0;
            cur_q <= '0;
            eq_q  <= 1'b0;
        end else if (!eq_q) begin
            if (pulse[0])
                val_q[{cur_q, 2'b00} +: 4] <= val_q[{cur_q, 2'b00} +: 4] + 4'd1;
            if (pulse[1])
                cur_q <= cur_q + 2'd1;
            if (pulse[3])
                eq_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) scan_cnt <= '0;
        else     scan_cnt <= scan_cnt + SCAN_N'(1);
    end

    assign sel = scan_cnt[SCAN_N-1 -: 2];

`ifdef CURSOR_BLINK_EN
    logic [25:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (rst) blink_cnt <= '0;
        else     blink_cnt <= blink_cnt + 26'd1;
    end

    assign blank = blink_cnt[25] && (sel == cur_q) && !eq_q;
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 4'b1111;
            dval_q <= '0;
        end else begin
            en_q <= blank ? 4'b1111 : ~(4'b0001 << sel);
            if (eq_q && sel == 2'd3)
                dval_q <= 5'd16;
            else
                dval_q <= {1'b0, val_q[{sel, 2'b00} +: 4]};
        end
    end

    assign bus.digit_en  = en_q;
    assign bus.digit_val = dval_q;
    assign bus.value     = val_q;
    assign bus.cursor    = cur_q;
    assign bus.eq_flag   = eq_q;
endmodule

// File: tb/tb_digit_entry_scan.sv
// tb_digit_entry_scan: scoreboard bench for digit_entry_scan with
// DEB_N=2, SCAN_N=4 (debounce window 4 cycles, scan slot 4 cycles).
module tb_digit_entry_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;

    digit_entry_scan_if bus ();

    digit_entry_scan #(
        .DEB_N  (2),
        .SCAN_N (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [1:0]  cursor;
        logic        eq;
    } st_t;

    st_t        sb_q[$];
    logic [8:0] scan_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] m_val = '0;
    logic [1:0]  m_cur = '0;
    logic        m_eq  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] m);
        {bus.btn_eq, bus.btn_clr, bus.btn_next, bus.btn_inc} = m;
    endtask

    // m = {eq, clr, next, inc}; a level held under 4 cycles is filtered.
    task automatic press(input logic [3:0] m, input int hold);
        st_t e;
        @(posedge clk);
        #1 set_btn(m);
        repeat (hold) @(posedge clk);
        #1 set_btn(4'b0000);
        if (hold >= 4) begin
            if (m[2]) begin
                m_val = '0;
                m_cur = '0;
                m_eq  = 1'b0;
            end else if (!m_eq) begin
                if (m[0]) m_val[4*m_cur +: 4] = m_val[4*m_cur +: 4] + 4'd1;
                if (m[1]) m_cur = m_cur + 2'd1;
                if (m[3]) m_eq = 1'b1;
            end
        end
        sb_q.push_back('{value: m_val, cursor: m_cur, eq: m_eq});
        repeat (12) @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        check("value", 32'(bus.value), 32'(e.value));
        check("cursor", 32'(bus.cursor), 32'(e.cursor));
        check("eq_flag", 32'(bus.eq_flag), 32'(e.eq));
    endtask

    // Expected full scan frame from the model, then align to a slot-0 start
    // and compare every cycle of the frame.
    task automatic scan_check(input string tag);
        logic [3:0] prev;
        logic [8:0] e;
        logic [4:0] v;
        int found;
        for (int s = 0; s < 4; s++) begin
            v = (m_eq && s == 3) ? 5'd16 : {1'b0, m_val[4*s +: 4]};
            for (int c = 0; c < 4; c++)
                scan_q.push_back({~(4'b0001 << s), v});
        end
        found = 0;
        prev  = bus.digit_en;
        for (int i = 0; i < 64 && found == 0; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && bus.digit_en == 4'b1110) found = 1;
            prev = bus.digit_en;
        end
        check({tag, "_sync"}, found, 1);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            e = scan_q.pop_front();
            if (found != 0) begin
                check({tag, "_en"}, 32'(bus.digit_en), 32'(e[8:5]));
                check({tag, "_val"}, 32'(bus.digit_val), 32'(e[4:0]));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        set_btn(4'b0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_en", 32'(bus.digit_en), 32'hF);
        check("rst_val", 32'(bus.digit_val), 0);
        check("rst_value", 32'(bus.value), 0);
        check("rst_cursor", 32'(bus.cursor), 0);
        check("rst_eq", 32'(bus.eq_flag), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_en", 32'(bus.digit_en), 32'hF);
        check("post_rst_val", 32'(bus.digit_val), 0);
        @(negedge clk);
        check("first_slot_en", 32'(bus.digit_en), 32'hE);

        press(4'b0001, 3);
        press(4'b0001, 10);
        for (int i = 0; i < 16; i++) press(4'b0001, 10);
        press(4'b0010, 10);
        press(4'b0001, 10);
        press(4'b0001, 10);
        check("v0021", 32'(bus.value), 32'h0021);

        press(4'b1000, 10);
        scan_check("eq_scan");
        press(4'b0001, 10);
        press(4'b0010, 10);
        press(4'b1000, 10);

        press(4'b0101, 10);
        press(4'b0011, 10);
        press(4'b0001, 40);
        check("v0011", 32'(bus.value), 32'h0011);
        press(4'b0100, 10);

        for (int i = 0; i < 3; i++) press(4'b0001, 10);
        press(4'b0010, 10);
        for (int i = 0; i < 12; i++) press(4'b0001, 10);
        press(4'b0010, 10);
        for (int i = 0; i < 5; i++) press(4'b0001, 10);
        press(4'b0010, 10);
        for (int i = 0; i < 10; i++) press(4'b0001, 10);
        check("vA5C3", 32'(bus.value), 32'hA5C3);
        scan_check("a5c3_scan");

        @(posedge clk);
        #1 set_btn(4'b0001);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_val = '0;
        m_cur = '0;
        m_eq  = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mid_deb_nopulse", 32'(bus.value), 0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("mid_deb_pulse", 32'(bus.value), 32'h0001);
        #1 set_btn(4'b0000);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("mid_deb_single", 32'(bus.value), 32'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
